// File: rtl/riscv_hazard_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller.
// One stage_t describes an instruction in flight after ID.
package riscv_pipe_pkg;

    localparam int RA_MAX_W    = 5;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                valid;
        logic [RA_MAX_W-1:0] rd;
        logic [RA_MAX_W-1:0] rs1;
        logic [RA_MAX_W-1:0] rs2;
        logic                rs1_used;
        logic                rs2_used;
        logic                regwrite;
        logic                memread;
    } stage_t;

    function automatic int sel_w(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    // x0 is hardwired, so a producer of x0 never counts
    function automatic logic is_match(
        input stage_t              e,
        input logic [RA_MAX_W-1:0] r
    );
        return e.valid && e.regwrite &&
               (e.rd != '0) && (e.rd == r);
    endfunction

endpackage

// File: rtl/riscv_hazard_ctrl_if.sv
// ID-side request and control responses of the hazard controller.
// master = decode/branch side, slave = hazard controller.
interface riscv_hazard_ctrl_if #(
    parameter int RA_W   = 5,
    parameter int STAGES = 3,
    parameter int CNT_W  = 32
);
    localparam int SEL_W = riscv_pipe_pkg::sel_w(STAGES);

    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RA_W-1:0]  id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             br_taken;

    logic             pc_write_en;
    logic             ifid_write_en;
    logic             flush_ifid;
    logic [SEL_W-1:0] fwd_a_sel;
    logic [SEL_W-1:0] fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2,
        output id_rs1_used, id_rs2_used,
        output id_rd, id_regwrite, id_memread,
        output br_taken,
        input  pc_write_en, ifid_write_en,
        input  flush_ifid,
        input  fwd_a_sel, fwd_b_sel,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2,
        input  id_rs1_used, id_rs2_used,
        input  id_rd, id_regwrite, id_memread,
        input  br_taken,
        output pc_write_en, ifid_write_en,
        output flush_ifid,
        output fwd_a_sel, fwd_b_sel,
        output stall_cnt, flush_cnt
    );

endinterface

// File: rtl/riscv_hazard_ctrl_stage.sv
// One back-end metadata register; kill turns the
// incoming entry into a bubble but keeps its fields.
module pipe_meta_stage
    import riscv_pipe_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_kill,
    input  stage_t i_d,
    output stage_t o_q
);

    stage_t r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            r_q       <= i_d;
            r_q.valid <= i_d.valid & ~i_kill;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Hazard/forwarding controller for the in-order pipeline:
// EX forwarding, load-use stall, branch flush, perf counters.
module riscv_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int STAGES   = 3,
    parameter int RA_W     = 5,
    parameter int LOAD_FWD = 2,
    parameter int BR_STAGE = 1,
    parameter int CNT_W    = 32
)(
    input  logic             clk,
    input  logic             rst,
    riscv_hazard_ctrl_if.slave hz
);

    localparam int SEL_W = sel_w(STAGES);

    stage_t              w_id;
    stage_t              w_d [STAGES];
    stage_t              w_q [STAGES];
    logic                w_kill [STAGES];
    logic [RA_W-1:0]     w_rs1_in;
    logic [RA_W-1:0]     w_rs2_in;
    logic [RA_W-1:0]     w_rd_in;
    logic                w_stall;
    logic [SEL_W-1:0]    w_fwd_a;
    logic [SEL_W-1:0]    w_fwd_b;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    assign w_rs1_in = hz.id_rs1;
    assign w_rs2_in = hz.id_rs2;
    assign w_rd_in  = hz.id_rd;

    always_comb begin
        w_id          = '0;
        w_id.valid    = hz.id_valid;
        w_id.rd       = RA_MAX_W'(w_rd_in);
        w_id.rs1      = RA_MAX_W'(w_rs1_in);
        w_id.rs2      = RA_MAX_W'(w_rs2_in);
        w_id.rs1_used = hz.id_rs1_used;
        w_id.rs2_used = hz.id_rs2_used;
        w_id.regwrite = hz.id_regwrite;
        w_id.memread  = hz.id_memread;
    end

    // loads younger than LOAD_FWD cannot supply data yet
    always_comb begin
        w_stall = 1'b0;
        for (int k = 0; k < LOAD_FWD - 1; k++) begin
            if (w_q[k].memread &&
                ((hz.id_rs1_used && is_match(w_q[k], w_id.rs1)) ||
                 (hz.id_rs2_used && is_match(w_q[k], w_id.rs2))))
                w_stall = 1'b1;
        end
        w_stall = w_stall & hz.id_valid;
    end

    // scan oldest to youngest so the youngest producer wins
    always_comb begin
        w_fwd_a = SEL_W'(FWD_REGFILE);
        w_fwd_b = SEL_W'(FWD_REGFILE);
        for (int k = STAGES - 1; k >= 1; k--) begin
            if (w_q[0].rs1_used && is_match(w_q[k], w_q[0].rs1))
                w_fwd_a = SEL_W'(k);
            if (w_q[0].rs2_used && is_match(w_q[k], w_q[0].rs2))
                w_fwd_b = SEL_W'(k);
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_d[g]    = w_id;
            assign w_kill[g] = w_stall | hz.br_taken;
        end else begin : g_tail
            assign w_d[g]    = w_q[g-1];
            assign w_kill[g] = (g <= BR_STAGE) ? hz.br_taken
                                               : 1'b0;
        end

        pipe_meta_stage u_stage (
            .clk    (clk),
            .rst    (rst),
            .i_kill (w_kill[g]),
            .i_d    (w_d[g]),
            .o_q    (w_q[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall && !hz.br_taken && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (hz.br_taken && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    assign hz.pc_write_en   = ~w_stall | hz.br_taken;
    assign hz.ifid_write_en = ~w_stall | hz.br_taken;
    assign hz.flush_ifid    = hz.br_taken & rst;
    assign hz.fwd_a_sel     = w_fwd_a;
    assign hz.fwd_b_sel     = w_fwd_b;
    assign hz.stall_cnt     = r_stall_cnt;
    assign hz.flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Directed bench for riscv_hazard_ctrl (STAGES=3, LOAD_FWD=2, BR_STAGE=1),
// plus a CNT_W=4 copy fed identically to exercise counter saturation.
module tb_riscv_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    always #5 clk = ~clk;

    riscv_hazard_ctrl_if #(.RA_W(5), .STAGES(3), .CNT_W(32)) hz ();
    riscv_hazard_ctrl_if #(.RA_W(5), .STAGES(3), .CNT_W(4))  hz4 ();

    riscv_hazard_ctrl #(
        .STAGES(3), .RA_W(5), .LOAD_FWD(2),
        .BR_STAGE(1), .CNT_W(32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    riscv_hazard_ctrl #(
        .STAGES(3), .RA_W(5), .LOAD_FWD(2),
        .BR_STAGE(1), .CNT_W(4)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .hz  (hz4.slave)
    );

    task automatic drive(input logic v,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2,
                         input logic [4:0] rd,
                         input logic rw, input logic mr);
        hz.id_valid     = v;   hz4.id_valid     = v;
        hz.id_rs1       = rs1; hz4.id_rs1       = rs1;
        hz.id_rs2       = rs2; hz4.id_rs2       = rs2;
        hz.id_rs1_used  = u1;  hz4.id_rs1_used  = u1;
        hz.id_rs2_used  = u2;  hz4.id_rs2_used  = u2;
        hz.id_rd        = rd;  hz4.id_rd        = rd;
        hz.id_regwrite  = rw;  hz4.id_regwrite  = rw;
        hz.id_memread   = mr;  hz4.id_memread   = mr;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic br(input logic b);
        hz.br_taken  = b;
        hz4.br_taken = b;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1);
        br(1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (hz.pc_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_pc_we: got %b want 1", hz.pc_write_en);
        end
        n_cmp++;
        if (hz.ifid_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_ifid_we: got %b want 1", hz.ifid_write_en);
        end
        n_cmp++;
        if (hz.flush_ifid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flush: got %b want 0", hz.flush_ifid);
        end
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd0 || hz.fwd_b_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_fwd: got a=%0d b=%0d want 0/0",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        n_cmp++;
        if (hz.stall_cnt !== 32'd0 || hz.flush_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_cnt: got s=%0d f=%0d want 0/0",
                     hz.stall_cnt, hz.flush_cnt);
        end
        nop();
        br(1'b0);
        #2 rst = 1'b1;
        tick();
        n_cmp++;
        if (hz.pc_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL rel_pc_we: got %b want 1", hz.pc_write_en);
        end
    endtask

    task automatic test_fwd_alu();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (hz.pc_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL alu_nostall: got %b want 1", hz.pc_write_en);
        end
        tick();
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd1 || hz.fwd_b_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL alu_fwd_mem: got a=%0d b=%0d want 1/0",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd2 || hz.fwd_b_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL alu_fwd_wb: got a=%0d b=%0d want 2/2",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        drain();
    endtask

    task automatic test_load_use();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd6, 5'd1, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (hz.pc_write_en !== 1'b0 || hz.ifid_write_en !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_stall: got pc=%b ifid=%b want 0/0",
                     hz.pc_write_en, hz.ifid_write_en);
        end
        n_cmp++;
        if (hz.flush_ifid !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_noflush: got %b want 0", hz.flush_ifid);
        end
        tick();
        exp_stall++;
        n_cmp++;
        if (hz.pc_write_en !== 1'b1 || hz.ifid_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_release: got pc=%b ifid=%b want 1/1",
                     hz.pc_write_en, hz.ifid_write_en);
        end
        n_cmp++;
        if (hz.stall_cnt !== 32'(exp_stall)) begin
            n_bad++;
            $display("FAIL lu_cnt: got %0d want %0d",
                     hz.stall_cnt, exp_stall);
        end
        tick();
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd2 || hz.fwd_b_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL lu_fwd_wb: got a=%0d b=%0d want 2/0",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        drain();
    endtask

    task automatic test_x0();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1);
        tick();
        n_cmp++;
        if (hz.pc_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL x0_nostall_ld: got %b want 1", hz.pc_write_en);
        end
        repeat (2) tick();
        drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (hz.pc_write_en !== 1'b1 || hz.ifid_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL x0_nostall: got pc=%b ifid=%b want 1/1",
                     hz.pc_write_en, hz.ifid_write_en);
        end
        tick();
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd0 || hz.fwd_b_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL x0_fwd: got a=%0d b=%0d want 0/0",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        n_cmp++;
        if (hz.stall_cnt !== 32'(exp_stall)) begin
            n_bad++;
            $display("FAIL x0_cnt: got %0d want %0d",
                     hz.stall_cnt, exp_stall);
        end
        drain();
    endtask

    task automatic test_youngest();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
        tick();
        n_cmp++;
        if (hz.fwd_b_sel !== 2'd1 || hz.fwd_a_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL young_fwd: got a=%0d b=%0d want 0/1",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        drain();
    endtask

    task automatic test_flush_stall();
        drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd6, 5'd11, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
        br(1'b1);
        #1;
        n_cmp++;
        if (hz.flush_ifid !== 1'b1) begin
            n_bad++;
            $display("FAIL fl_flush: got %b want 1", hz.flush_ifid);
        end
        n_cmp++;
        if (hz.pc_write_en !== 1'b1 || hz.ifid_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL fl_override: got pc=%b ifid=%b want 1/1",
                     hz.pc_write_en, hz.ifid_write_en);
        end
        tick();
        exp_flush++;
        br(1'b0);
        drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd0 || hz.fwd_b_sel !== 2'd2) begin
            n_bad++;
            $display("FAIL fl_kill_idx1: got a=%0d b=%0d want 0/2",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        n_cmp++;
        if (hz.stall_cnt !== 32'(exp_stall) ||
            hz.flush_cnt !== 32'(exp_flush)) begin
            n_bad++;
            $display("FAIL fl_cnt: got s=%0d f=%0d want %0d/%0d",
                     hz.stall_cnt, hz.flush_cnt, exp_stall, exp_flush);
        end
        tick();
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL fl_kill_idx0: got %0d want 0", hz.fwd_a_sel);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) tick();
        exp_stall += 20;
        n_cmp++;
        if (hz.pc_write_en !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_phase: got %b want 1", hz.pc_write_en);
        end
        nop();
        #1;
        n_cmp++;
        if (hz.stall_cnt !== 32'(exp_stall)) begin
            n_bad++;
            $display("FAIL b2b_cnt: got %0d want %0d",
                     hz.stall_cnt, exp_stall);
        end
        n_cmp++;
        if (hz4.stall_cnt !== 4'd15) begin
            n_bad++;
            $display("FAIL sat_cnt: got %0d want 15", hz4.stall_cnt);
        end
        n_cmp++;
        if (hz4.flush_cnt !== 4'(exp_flush)) begin
            n_bad++;
            $display("FAIL sat_flush: got %0d want %0d",
                     hz4.flush_cnt, exp_flush);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
        tick();
        drive(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
        #1;
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd1 || hz.pc_write_en !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_pre: got a=%0d pc=%b want 1/0",
                     hz.fwd_a_sel, hz.pc_write_en);
        end
        rst = 1'b0;
        br(1'b1);
        #1;
        n_cmp++;
        if (hz.pc_write_en !== 1'b1 || hz.ifid_write_en !== 1'b1 ||
            hz.flush_ifid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_ctl: got pc=%b ifid=%b fl=%b want 1/1/0",
                     hz.pc_write_en, hz.ifid_write_en, hz.flush_ifid);
        end
        n_cmp++;
        if (hz.fwd_a_sel !== 2'd0 || hz.fwd_b_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_fwd: got a=%0d b=%0d want 0/0",
                     hz.fwd_a_sel, hz.fwd_b_sel);
        end
        n_cmp++;
        if (hz.stall_cnt !== 32'd0 || hz.flush_cnt !== 32'd0 ||
            hz4.stall_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL mid_cnt: got s=%0d f=%0d s4=%0d want 0/0/0",
                     hz.stall_cnt, hz.flush_cnt, hz4.stall_cnt);
        end
    endtask

    initial begin
        nop();
        br(1'b0);
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_x0();
        test_youngest();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, summary not reached");
        $fatal(1);
    end

endmodule
